// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns the 3x3 board, takes moves via valid/ready,
// alternates turns and turns the external win checker's verdict into winner/draw.
module ttt_game_ctrl #(
    parameter logic FIRST_PLAYER = 1'b1,
    parameter logic ALT_START    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    input  logic       win_in,
    output logic [1:0] v11,
    output logic [1:0] v12,
    output logic [1:0] v13,
    output logic [1:0] v21,
    output logic [1:0] v22,
    output logic [1:0] v23,
    output logic [1:0] v31,
    output logic [1:0] v32,
    output logic [1:0] v33,
    output logic       check_turn,
    output logic       turn,
    output logic [3:0] move_count,
    output logic       illegal,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);

    typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

    state_t          state_reg, state_next;
    logic [8:0][1:0] board_reg, board_next;
    logic            turn_reg, turn_next;
    logic            check_reg, check_next;
    logic            start_reg, start_next;
    logic [3:0]      count_reg, count_next;
    logic            illegal_reg, illegal_next;
    logic            draw_reg, draw_next;
    logic [1:0]      winner_reg, winner_next;
    logic [15:0]     busy_vec;
    logic [1:0]      mark;

    // Indices 9..15 read as occupied so one lookup rejects both bad cases.
    assign busy_vec[15:9] = '1;
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_busy
            assign busy_vec[gi] = |board_reg[gi];
        end
    endgenerate

    assign mark = turn_reg ? 2'b10 : 2'b01;

    always_comb begin
        state_next   = state_reg;
        board_next   = board_reg;
        turn_next    = turn_reg;
        check_next   = check_reg;
        start_next   = start_reg;
        count_next   = count_reg;
        illegal_next = 1'b0;
        draw_next    = draw_reg;
        winner_next  = winner_reg;

        if (new_game) begin
            board_next  = '0;
            count_next  = 4'd0;
            winner_next = 2'b00;
            draw_next   = 1'b0;
            state_next  = PLAY;
            start_next  = ALT_START ? ~start_reg : start_reg;
            turn_next   = ALT_START ? ~start_reg : FIRST_PLAYER;
            check_next  = turn_next;
        end else begin
            case (state_reg)
                PLAY: begin
                    if (move_valid) begin
                        if (!busy_vec[move_pos]) begin
                            for (int i = 0; i < 9; i++) begin
                                if (move_pos == 4'(i)) board_next[i] = mark;
                            end
                            check_next = turn_reg;
                            count_next = (count_reg == 4'd9) ? 4'd9 : count_reg + 4'd1;
                            state_next = CHECK;
                        end else begin
                            illegal_next = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (win_in) begin
                        winner_next = check_reg ? 2'b10 : 2'b01;
                        state_next  = DONE;
                    end else if (count_reg == 4'd9) begin
                        draw_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        turn_next  = ~turn_reg;
                        state_next = PLAY;
                    end
                end
                DONE:    state_next = DONE;
                default: state_next = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= PLAY;
            board_reg   <= '0;
            turn_reg    <= FIRST_PLAYER;
            check_reg   <= FIRST_PLAYER;
            start_reg   <= FIRST_PLAYER;
            count_reg   <= 4'd0;
            illegal_reg <= 1'b0;
            draw_reg    <= 1'b0;
            winner_reg  <= 2'b00;
        end else begin
            state_reg   <= state_next;
            board_reg   <= board_next;
            turn_reg    <= turn_next;
            check_reg   <= check_next;
            start_reg   <= start_next;
            count_reg   <= count_next;
            illegal_reg <= illegal_next;
            draw_reg    <= draw_next;
            winner_reg  <= winner_next;
        end
    end

    assign v11        = board_reg[0];
    assign v12        = board_reg[1];
    assign v13        = board_reg[2];
    assign v21        = board_reg[3];
    assign v22        = board_reg[4];
    assign v23        = board_reg[5];
    assign v31        = board_reg[6];
    assign v32        = board_reg[7];
    assign v33        = board_reg[8];
    assign move_ready = (state_reg == PLAY);
    assign game_over  = (state_reg == DONE);
    assign check_turn = check_reg;
    assign turn       = turn_reg;
    assign move_count = count_reg;
    assign illegal    = illegal_reg;
    assign winner     = winner_reg;
    assign draw       = draw_reg;

endmodule
